// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder (with the Adder1bit full-adder cell)
// Purpose  : Bit-serial WIDTH-bit adder. On an accepted start it latches A, B
//            and Cin. It then feeds one bit pair per clock, LSB first, through
//            the single Adder1bit cell, using a registered carry loop. The
//            serial sum is reassembled into a parallel result with carry-out,
//            and completion is flagged with a one-cycle done pulse.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous, active-high reset
//            start - request, sampled only in IDLE (and in the done cycle)
//            A, B  - WIDTH-bit operands, sampled on the accepting edge
//            Cin   - initial carry, sampled on the accepting edge
//            busy  - high while an addition is in progress
//            done  - one-cycle completion pulse
//            S     - registered sum of the last completed addition
//            Cout  - registered carry-out of the last completed addition
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Adder1bit: existing 1-bit full adder cell (purely combinational).
// Ports: a, b, ci inputs; s sum, co carry-out.
// ----------------------------------------------------------------------------
module Adder1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  // The counter must hold 0..WIDTH-1. It still needs one bit when WIDTH is 1.
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;

  Adder1bit u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // The new sum bit enters at the MSB, so after WIDTH shifts the LSB-first
  // stream sits in natural bit order.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_s;
    end else begin : g_sum_wn
      assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_s      <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // done lasts only one cycle. A start in the done cycle is accepted
          // here, which gives back-to-back operation.
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= A;
            r_b_sr  <= B;
            r_carry <= Cin;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sum_sr <= w_sum_next;
          r_carry  <= w_co;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == LAST) begin
            // S and Cout are updated only here, so they never show a partial sum.
            r_s     <= w_sum_next;
            r_cout  <= w_co;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign S    = r_s;
  assign Cout = r_cout;

endmodule
`default_nettype wire
